// File: rtl/load_writeback.sv
// Writeback stage in front of the RV32I register file: forwards ALU results,
// issues loads to data memory, then aligns and extends the returned word.
module load_writeback #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_alu_result,
    input  logic [4:0]  req_rd,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        reg_write_enable,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WB       = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_read_en_q, mem_read_en_d;
    logic        we_q, we_d;
    logic        load_err_q, load_err_d;

    logic        req_bad;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [7:0]  cnt_inc;

    // Illegal funct3 and misaligned accesses are rejected identically.
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            F3_LB, F3_LBU: req_bad = 1'b0;
            F3_LH, F3_LHU: req_bad = req_addr[0];
            F3_LW:         req_bad = (req_addr[1:0] != 2'b00);
            default:       req_bad = 1'b1;
        endcase
    end

    always_comb begin
        byte_val = mem_rdata[7:0];
        case (addr_lo_q)
            2'd0: byte_val = mem_rdata[7:0];
            2'd1: byte_val = mem_rdata[15:8];
            2'd2: byte_val = mem_rdata[23:16];
            2'd3: byte_val = mem_rdata[31:24];
            default: byte_val = mem_rdata[7:0];
        endcase
        half_val = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val = mem_rdata;
        case (funct3_q)
            F3_LB:   load_val = {{24{byte_val[7]}}, byte_val};
            F3_LBU:  load_val = {24'd0, byte_val};
            F3_LH:   load_val = {{16{half_val[15]}}, half_val};
            F3_LHU:  load_val = {16'd0, half_val};
            default: load_val = mem_rdata;
        endcase
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        mem_addr_d    = mem_addr_q;
        mem_read_en_d = 1'b0;
        we_d          = 1'b0;
        load_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_addr_d = req_rd;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    if (!req_is_load) begin
                        rd_data_d = req_alu_result;
                        we_d      = (req_rd != 5'd0);
                        state_d   = WB;
                    end else if (req_bad) begin
                        load_err_d = 1'b1;
                    end else begin
                        mem_addr_d    = {req_addr[31:2], 2'b00};
                        mem_read_en_d = 1'b1;
                        cnt_d         = 8'd0;
                        state_d       = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // The strobe cycle is the first MEM_WAIT cycle; rvalid is not honoured there.
                if (mem_rvalid && !mem_read_en_q) begin
                    rd_data_d = load_val;
                    we_d      = (rd_addr_q != 5'd0);
                    state_d   = WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            funct3_q      <= 3'd0;
            addr_lo_q     <= 2'd0;
            rd_addr_q     <= 5'd0;
            rd_data_q     <= 32'd0;
            mem_addr_q    <= 32'd0;
            mem_read_en_q <= 1'b0;
            we_q          <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_en_q <= mem_read_en_d;
            we_q          <= we_d;
            load_err_q    <= load_err_d;
        end
    end

    // Gated by rst_n so execute never sees ready while reset is held.
    assign req_ready        = (state_q == IDLE) && rst_n;
    assign mem_read_en      = mem_read_en_q;
    assign mem_addr         = mem_addr_q;
    assign rd_addr          = rd_addr_q;
    assign rd_data          = rd_data_q;
    assign reg_write_enable = we_q;
    assign load_err         = load_err_q;

endmodule
